dmem_ctrl: RTL and testbench

- Two-master access controller in front of the byte-addressed data memory (1 KiB, RISC-V func3 load/store encoding).
- Masters:
  - M0 is the CPU load/store stage.
  - M1 is the program-loader/debug port.
- Round-robin arbitration, one transaction in flight.
- Sequences each request into the memory-safe access cycles the data memory requires, then returns data or status.

---
 rtl/dmem_ctrl_pkg.sv | 44 ++++
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_rr_arb.sv | 25 ++
 rtl/dmem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared constants, state encoding and command bundle for the
// two-master data-memory access controller.
package dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_PARK = 3'b011;

    // Side-effect-free read codes used for every load cycle
    localparam logic [2:0] F3_RD_B = 3'b100;
    localparam logic [2:0] F3_RD_H = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        ST_B0,
        ST_B1,
        ST_W,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
    } cmd_t;

    function automatic logic [2:0] acc_size(input logic [1:0] sz);
        case (sz)
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response port between one master and the data-memory
// controller.
interface dmem_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, func3,
        input  ack, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, func3,
        output ack, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter; rr_last holds the most recent winner.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = rr_last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       rr_last <= 1'b1;
        else if (|gnt) rr_last <= gnt[1];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-master data-memory controller: arbitrates, checks, and splits
// each request into the memory-safe access cycles.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [2:0]  PARK_F3   = F3_PARK
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  m0,
    dmem_ctrl_if.slave  m1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_data_out
);

    state_t      state, state_nx;
    cmd_t        cmd_in, cmd_q;
    logic        owner_q, err_q;
    logic [31:0] rdata_q, ld_val;
    logic [1:0]  gnt;
    logic        grant, cmd_err, resp, rv0, rv1;
    logic        f3_ok, mis, oor;
    logic [32:0] end_addr;

    dmem_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1.req, m0.req}),
        .en  (state == IDLE && !rst),
        .gnt (gnt)
    );

    assign grant = |gnt;

    always_comb begin
        if (gnt[1]) begin
            cmd_in.we    = m1.we;
            cmd_in.addr  = m1.addr;
            cmd_in.wdata = m1.wdata;
            cmd_in.func3 = m1.func3;
        end else begin
            cmd_in.we    = m0.we;
            cmd_in.addr  = m0.addr;
            cmd_in.wdata = m0.wdata;
            cmd_in.func3 = m0.func3;
        end
    end

    // Range is checked in 33 bits so a wrapping address cannot pass
    always_comb begin
        if (cmd_in.we)
            f3_ok = cmd_in.func3 inside {F3_SB, F3_SH, F3_SW};
        else
            f3_ok = cmd_in.func3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        mis = (cmd_in.func3[1:0] == 2'b01 && cmd_in.addr[0]) ||
              (cmd_in.func3[1:0] == 2'b10 && cmd_in.addr[1:0] != 2'b00);
        end_addr = {1'b0, cmd_in.addr} + {30'b0, acc_size(cmd_in.func3[1:0])};
        oor = end_addr > 33'(MEM_BYTES);
        cmd_err = !f3_ok || mis || oor;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (cmd_err)                      state_nx = RESP;
                    else if (!cmd_in.we)              state_nx = LD_LO;
                    else if (cmd_in.func3 == F3_SW)   state_nx = ST_W;
                    else                              state_nx = ST_B0;
                end
            end
            LD_LO:   state_nx = (cmd_q.func3 == F3_LW) ? LD_HI : RESP;
            ST_B0:   state_nx = (cmd_q.func3 == F3_SH) ? ST_B1 : RESP;
            LD_HI,
            ST_B1,
            ST_W:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Halfword stores go out as two byte commits; code 001 is never used
    always_comb begin
        mem_addr       = cmd_q.addr;
        mem_write_data = cmd_q.wdata;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_func3      = PARK_F3;
        unique case (state)
            LD_LO: begin
                mem_read  = 1'b1;
                mem_func3 = (cmd_q.func3[1:0] == 2'b00) ? F3_RD_B : F3_RD_H;
            end
            LD_HI: begin
                mem_read  = 1'b1;
                mem_func3 = F3_RD_H;
                mem_addr  = cmd_q.addr + 32'd2;
            end
            ST_B0: begin
                mem_write      = 1'b1;
                mem_func3      = F3_SB;
                mem_write_data = {24'b0, cmd_q.wdata[7:0]};
            end
            ST_B1: begin
                mem_write      = 1'b1;
                mem_func3      = F3_SB;
                mem_addr       = cmd_q.addr + 32'd1;
                mem_write_data = {24'b0, cmd_q.wdata[15:8]};
            end
            ST_W: begin
                mem_write = 1'b1;
                mem_func3 = F3_SW;
            end
            default: ;
        endcase
        if (rst) begin
            mem_write = 1'b0;
            mem_read  = 1'b0;
            mem_func3 = PARK_F3;
        end
    end

    always_comb begin
        resp      = (state == RESP) && !rst;
        rv0       = resp && !owner_q;
        rv1       = resp && owner_q;
        m0.ack    = gnt[0];
        m1.ack    = gnt[1];
        m0.rvalid = rv0;
        m1.rvalid = rv1;
        m0.rdata  = rv0 ? rdata_q : 32'h0;
        m1.rdata  = rv1 ? rdata_q : 32'h0;
        m0.err    = rv0 && err_q;
        m1.err    = rv1 && err_q;
    end

    // For LW the upper half taken here is replaced in LD_HI
    always_comb begin
        unique case (cmd_q.func3)
            F3_LB:   ld_val = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            F3_LBU:  ld_val = {24'b0, mem_data_out[7:0]};
            F3_LH:   ld_val = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            F3_LHU:  ld_val = {16'b0, mem_data_out[15:0]};
            default: ld_val = mem_data_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else if (grant) begin
            cmd_q   <= cmd_in;
            owner_q <= gnt[1];
            err_q   <= cmd_err;
            rdata_q <= 32'h0;
        end else if (state == LD_LO) begin
            rdata_q <= ld_val;
        end else if (state == LD_HI) begin
            rdata_q[31:16] <= mem_data_out[15:0];
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural 1 KiB byte memory
// that commits on store codes exactly as the real memory does.
module tb_dmem_ctrl;

    typedef struct {
        int          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          com;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if p0 ();
    dmem_ctrl_if p1 ();

    logic [1:0]  req_v = 2'b00;
    logic [1:0]  we_v = 2'b00;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic [2:0]  f3_v [2];
    logic [1:0]  ack_v, rvalid_v, err_v;
    logic [31:0] rdata_v [2];

    logic [31:0] mem_addr, mem_write_data, mem_data_out;
    logic        mem_write, mem_read;
    logic [2:0]  mem_func3;

    assign p0.req = req_v[0];
    assign p1.req = req_v[1];
    assign p0.we = we_v[0];
    assign p1.we = we_v[1];
    assign p0.addr = addr_v[0];
    assign p1.addr = addr_v[1];
    assign p0.wdata = wdata_v[0];
    assign p1.wdata = wdata_v[1];
    assign p0.func3 = f3_v[0];
    assign p1.func3 = f3_v[1];
    assign ack_v = {p1.ack, p0.ack};
    assign rvalid_v = {p1.rvalid, p0.rvalid};
    assign err_v = {p1.err, p0.err};
    assign rdata_v[0] = p0.rdata;
    assign rdata_v[1] = p1.rdata;

    dmem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .m0             (p0),
        .m1             (p1),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_func3      (mem_func3),
        .mem_data_out   (mem_data_out)
    );

    logic [7:0] mem_arr [0:1023] = '{default: 8'h00};
    logic [9:0] ma;
    assign ma = mem_addr[9:0];

    always_comb begin
        mem_data_out = 32'h0;
        case (mem_func3)
            3'b100:  mem_data_out = {24'h0, mem_arr[ma]};
            3'b101:  mem_data_out = {16'h0, mem_arr[ma + 10'd1], mem_arr[ma]};
            default: mem_data_out = {mem_arr[ma + 10'd3], mem_arr[ma + 10'd2],
                                     mem_arr[ma + 10'd1], mem_arr[ma]};
        endcase
    end

    int cyc = 0;
    int commits = 0;
    int bad_cyc = 0;
    int rv_cnt = 0;
    int nresp = 0;
    int errors = 0;
    int checks = 0;
    bit log_en = 1'b0;
    int glog [$];

    always @(posedge clk) cyc <= cyc + 1;

    // The memory commits on any store code, whatever mem_write says
    always @(posedge clk) begin
        if (!rst && mem_func3 inside {3'b000, 3'b001, 3'b010}) begin
            commits++;
            mem_arr[ma] <= mem_write_data[7:0];
            if (mem_func3 != 3'b000) mem_arr[ma + 10'd1] <= mem_write_data[15:8];
            if (mem_func3 == 3'b010) begin
                mem_arr[ma + 10'd2] <= mem_write_data[23:16];
                mem_arr[ma + 10'd3] <= mem_write_data[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (!((mem_func3 == 3'b011 && !mem_write && !mem_read) ||
              (mem_write && !mem_read && mem_func3 inside {3'b000, 3'b010}) ||
              (mem_read && !mem_write && mem_func3 inside {3'b100, 3'b101})))
            bad_cyc++;
        if (ack_v == 2'b11) bad_cyc++;
        if (|rvalid_v) rv_cnt++;
        if (log_en && ack_v[0]) glog.push_back(0);
        if (log_en && ack_v[1]) glog.push_back(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int m, input bit w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           output logic [31:0] rd, output bit e,
                           output int lat, output int aw);
        int c0, ca;
        rd = 32'h0;
        e = 1'b0;
        lat = -1;
        aw = -1;
        we_v[m] = w;
        addr_v[m] = a;
        wdata_v[m] = wd;
        f3_v[m] = f3;
        req_v[m] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        while (!ack_v[m] && cyc - c0 < 40) @(negedge clk);
        if (!ack_v[m]) begin
            req_v[m] = 1'b0;
            errors++;
            checks++;
            $display("FAIL m%0d_ack_timeout: no ack in %0d cycles", m, cyc - c0);
            return;
        end
        ca = cyc;
        aw = ca - c0;
        @(posedge clk);
        #1 req_v[m] = 1'b0;
        @(negedge clk);
        while (!rvalid_v[m] && cyc - ca < 10) @(negedge clk);
        if (rvalid_v[m]) begin
            rd = rdata_v[m];
            e = err_v[m];
            lat = cyc - ca;
            nresp++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int m, bit we, logic [31:0] a, logic [31:0] wd,
                                logic [2:0] f3, logic [31:0] rd, bit err,
                                int lat, int com);
        vec_t v;
        v.m = m; v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3;
        v.rd = rd; v.err = err; v.lat = lat; v.com = com;
        return v;
    endfunction

    vec_t vt [$];

    initial begin
        logic [31:0] rd;
        bit          e;
        int          lat, aw, cb, c0, rv0;
        logic [3:0]  order;

        vt.push_back(mk(0, 1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 2, 1));
        vt.push_back(mk(0, 0, 32'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 3, 0));
        vt.push_back(mk(1, 1, 32'h021, 32'h0000A5C3, 3'b001, 32'h0, 1, 1, 0));
        vt.push_back(mk(1, 0, 32'h020, 32'h0, 3'b001, 32'h0, 0, 2, 0));
        vt.push_back(mk(1, 1, 32'h020, 32'h0000A5C3, 3'b001, 32'h0, 0, 3, 2));
        vt.push_back(mk(1, 0, 32'h020, 32'h0, 3'b001, 32'hFFFFA5C3, 0, 2, 0));
        vt.push_back(mk(1, 0, 32'h020, 32'h0, 3'b101, 32'h0000A5C3, 0, 2, 0));
        vt.push_back(mk(0, 1, 32'h007, 32'h12345680, 3'b000, 32'h0, 0, 2, 1));
        vt.push_back(mk(0, 0, 32'h004, 32'h0, 3'b010, 32'h80000000, 0, 3, 0));
        vt.push_back(mk(0, 0, 32'h007, 32'h0, 3'b000, 32'hFFFFFF80, 0, 2, 0));
        vt.push_back(mk(0, 0, 32'h007, 32'h0, 3'b100, 32'h00000080, 0, 2, 0));
        vt.push_back(mk(0, 0, 32'h3FE, 32'h0, 3'b010, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h400, 32'h0, 3'b010, 32'h0, 1, 1, 0));
        vt.push_back(mk(1, 1, 32'h400, 32'h11111111, 3'b010, 32'h0, 1, 1, 0));
        vt.push_back(mk(1, 1, 32'h3FC, 32'h12345678, 3'b010, 32'h0, 0, 2, 1));
        vt.push_back(mk(1, 0, 32'h3FC, 32'h0, 3'b010, 32'h12345678, 0, 3, 0));
        vt.push_back(mk(0, 0, 32'h3FF, 32'h0, 3'b100, 32'h00000012, 0, 2, 0));
        vt.push_back(mk(0, 0, 32'h3FE, 32'h0, 3'b101, 32'h00001234, 0, 2, 0));
        vt.push_back(mk(0, 0, 32'h400, 32'h0, 3'b000, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h3FF, 32'h0, 3'b001, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h010, 32'h0, 3'b110, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h010, 32'h0, 3'b011, 32'h0, 1, 1, 0));
        vt.push_back(mk(1, 1, 32'h010, 32'h55555555, 3'b100, 32'h0, 1, 1, 0));
        vt.push_back(mk(1, 1, 32'h010, 32'h55555555, 3'b011, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h012, 32'h0, 3'b010, 32'h0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 3, 0));

        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 32'h0;
            wdata_v[i] = 32'h0;
            f3_v[i] = 3'b010;
        end

        // A request held during reset must not be acknowledged
        req_v[0] = 1'b1;
        addr_v[0] = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", ack_v[0], 1'b0);
        chk("rst_f3", mem_func3, 3'b011);
        chk("rst_rd", mem_read, 1'b0);
        chk("rst_wr", mem_write, 1'b0);
        chk("rst_rvalid", rvalid_v, 2'b00);
        req_v[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_rdata0", rdata_v[0], 32'h0);
        chk("idle_err", err_v, 2'b00);
        chk("idle_f3", mem_func3, 3'b011);
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            cb = commits;
            run_txn(vt[i].m, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].f3,
                    rd, e, lat, aw);
            chk($sformatf("v%0d_err", i), e, vt[i].err);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_commits", i), commits - cb, vt[i].com);
        end

        // Reset lands in LD_HI of an LW: no response, outputs parked
        we_v[0] = 1'b0;
        addr_v[0] = 32'h10;
        f3_v[0] = 3'b010;
        req_v[0] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        while (!ack_v[0] && cyc - c0 < 10) @(negedge clk);
        chk("rst_lw_ack", ack_v[0], 1'b1);
        @(posedge clk);
        #1 req_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ldhi_read", mem_read, 1'b1);
        chk("rst_ldhi_addr", mem_addr, 32'h12);
        chk("rst_ldhi_f3", mem_func3, 3'b101);
        rv0 = rv_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_f3", mem_func3, 3'b011);
        chk("rst_mid_rw", {mem_read, mem_write}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_rvalid", rv_cnt - rv0, 0);
        @(posedge clk);
        #1;

        // Both masters held: after reset M0 wins first, then alternate
        log_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    logic [31:0] r0;
                    bit          e0;
                    int          l0, a0;
                    run_txn(0, 1'b0, 32'h10, 32'h0, 3'b010, r0, e0, l0, a0);
                    chk($sformatf("arb_m0_%0d_rdata", k), r0, 32'hDEADBEEF);
                    chk($sformatf("arb_m0_%0d_lat", k), l0, 3);
                    if (k == 0) chk("arb_m0_first_wait", a0, 0);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    logic [31:0] r1;
                    bit          e1;
                    int          l1, a1;
                    run_txn(1, 1'b0, 32'h20, 32'h0, 3'b101, r1, e1, l1, a1);
                    chk($sformatf("arb_m1_%0d_rdata", k), r1, 32'h0000A5C3);
                    chk($sformatf("arb_m1_%0d_lat", k), l1, 2);
                end
            end
        join
        log_en = 1'b0;

        chk("arb_count", glog.size(), 4);
        order = 4'hF;
        if (glog.size() == 4)
            order = {glog[0][0], glog[1][0], glog[2][0], glog[3][0]};
        chk("arb_order", order, 4'b0101);

        repeat (2) @(negedge clk);
        chk("protocol_cycles", bad_cyc, 0);
        chk("rvalid_count", rv_cnt, nresp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
